// File: rtl/dmem_access_master.sv
// rtl/dmem_access_master.sv - data-memory port initiator: single/double word load/store sequencing
// All outputs are registered from the next-state decode; read data is tracked by a latency tag pipe.
module dmem_access_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata0,
  output logic [31:0] resp_rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic        ldw_sdw,
  output logic        second_cycle
);

  typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_WAIT, S_RESP} state_t;

  state_t state, nxt;

  logic [1:0]        op_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata1_q;
  logic [31:0]       rbuf0;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_i;
  logic              tag_last_v, tag_last_i, cap0, accept;

  logic        req_ready_d, resp_valid_d, resp_err_d;
  logic        mem_read_d, mem_write_d, ldw_sdw_d, second_cycle_d;
  logic [31:0] mem_address_d, mem_data_out_d;

  assign accept     = req_valid & req_ready;
  assign tag_last_v = tag_v[RD_LAT-1];
  assign tag_last_i = tag_i[RD_LAT-1];
  assign cap0       = tag_last_v & ~tag_last_i;

  // op[0] set means store, op[1] set means double-word
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) nxt = (req_op[1] && req_addr[0]) ? S_RESP : S_ACC1;
      S_ACC1: nxt = op_q[1] ? S_ACC2 : (op_q[0] ? S_RESP : S_WAIT);
      S_ACC2: nxt = op_q[0] ? S_RESP : S_WAIT;
      S_WAIT: if (tag_last_v && (tag_last_i == op_q[1])) nxt = S_RESP;
      S_RESP: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // ACC1 is only ever entered from IDLE, so it takes the live request fields
  always_comb begin
    req_ready_d    = (nxt == S_IDLE);
    resp_valid_d   = (nxt == S_RESP);
    resp_err_d     = (state == S_IDLE) && (nxt == S_RESP);
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    ldw_sdw_d      = 1'b0;
    second_cycle_d = 1'b0;
    mem_address_d  = 32'h0;
    mem_data_out_d = 32'h0;
    if (nxt == S_ACC1) begin
      mem_read_d     = ~req_op[0];
      mem_write_d    = req_op[0];
      ldw_sdw_d      = req_op[1];
      mem_address_d  = req_addr;
      mem_data_out_d = req_op[0] ? req_wdata0 : 32'h0;
    end else if (nxt == S_ACC2) begin
      mem_read_d     = ~op_q[0];
      mem_write_d    = op_q[0];
      ldw_sdw_d      = 1'b1;
      second_cycle_d = 1'b1;
      mem_address_d  = addr_q + 32'd1;
      mem_data_out_d = op_q[0] ? wdata1_q : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= 2'b00;
      addr_q       <= 32'h0;
      wdata1_q     <= 32'h0;
      rbuf0        <= 32'h0;
      tag_v        <= '0;
      tag_i        <= '0;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata0  <= 32'h0;
      resp_rdata1  <= 32'h0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      ldw_sdw      <= 1'b0;
      second_cycle <= 1'b0;
      mem_address  <= 32'h0;
      mem_data_out <= 32'h0;
    end else begin
      state        <= nxt;
      req_ready    <= req_ready_d;
      resp_valid   <= resp_valid_d;
      resp_err     <= resp_err_d;
      mem_read     <= mem_read_d;
      mem_write    <= mem_write_d;
      ldw_sdw      <= ldw_sdw_d;
      second_cycle <= second_cycle_d;
      mem_address  <= mem_address_d;
      mem_data_out <= mem_data_out_d;
      if (accept) begin
        op_q     <= req_op;
        addr_q   <= req_addr;
        wdata1_q <= req_wdata1;
      end
      // A tag enters for each cycle the registered read strobe is on the bus
      tag_v <= (tag_v << 1) | RD_LAT'(mem_read);
      tag_i <= (tag_i << 1) | RD_LAT'(second_cycle);
      if (cap0) rbuf0 <= mem_data_in;
      // The final word is taken straight from the bus on the edge entering RESP
      if (state == S_WAIT && nxt == S_RESP) begin
        resp_rdata0 <= cap0 ? mem_data_in : rbuf0;
        if (op_q[1]) resp_rdata1 <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_master.sv
// tb/tb_dmem_access_master.sv - directed self-checking bench for dmem_access_master
// Instance a uses RD_LAT=1, instance b uses RD_LAT=3; both see the same request stream.
module tb_dmem_access_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata0, req_wdata1;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_read, a_mem_write, a_ldw_sdw, a_second_cycle;
  logic [31:0] a_resp_rdata0, a_resp_rdata1, a_mem_address, a_mem_data_out, a_mem_data_in;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_read, b_mem_write, b_ldw_sdw, b_second_cycle;
  logic [31:0] b_resp_rdata0, b_resp_rdata1, b_mem_address, b_mem_data_out, b_mem_data_in;
  logic [31:0] b_p0, b_p1;

  int checks = 0;
  int failures = 0;
  int a_strobes = 0;
  int a_resps = 0;
  int accepts = 0;
  int overlaps = 0;
  int snap;

  always #5 clk = ~clk;

  dmem_access_master #(.RD_LAT(1)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_rdata0(a_resp_rdata0), .resp_rdata1(a_resp_rdata1),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address), .mem_data_out(a_mem_data_out),
    .mem_data_in(a_mem_data_in), .ldw_sdw(a_ldw_sdw), .second_cycle(a_second_cycle)
  );

  dmem_access_master #(.RD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata0(b_resp_rdata0), .resp_rdata1(b_resp_rdata1),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address), .mem_data_out(b_mem_data_out),
    .mem_data_in(b_mem_data_in), .ldw_sdw(b_ldw_sdw), .second_cycle(b_second_cycle)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10:  mem_val = 32'hDEADBEEF;
      32'h40:  mem_val = 32'h0000000A;
      32'h41:  mem_val = 32'h0000000B;
      default: mem_val = a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Memory models: data appears RD_LAT cycles after the read access cycle
  always @(posedge clk) begin
    a_mem_data_in <= a_mem_read ? mem_val(a_mem_address) : 32'h0;
    b_p0          <= b_mem_read ? mem_val(b_mem_address) : 32'h0;
    b_p1          <= b_p0;
    b_mem_data_in <= b_p1;
    if (a_mem_read || a_mem_write) a_strobes <= a_strobes + 1;
    if (a_resp_valid) a_resps <= a_resps + 1;
    if (req_valid && a_req_ready) accepts <= accepts + 1;
    if ((a_mem_read && a_mem_write) || (b_mem_read && b_mem_write)) overlaps <= overlaps + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata0 = w0; req_wdata1 = w1;
  endtask

  logic exp_resp [1:9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic exp_wr   [1:9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] exp_wd [1:9] = '{32'h100, 0, 0, 32'h200, 0, 0, 32'h300, 0, 0};

  initial begin
    req_valid = 1'b0; req_op = 2'b00; req_addr = 32'h0; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
    tick(); tick();
    check("rst_ready", a_req_ready, 0);
    check("rst_strobes", {a_mem_read, a_mem_write, a_ldw_sdw, a_second_cycle}, 0);
    check("rst_resp", {a_resp_valid, a_resp_err}, 0);
    reset = 1'b0;
    tick();
    check("ready_after_rst_a", a_req_ready, 1);
    check("ready_after_rst_b", b_req_ready, 1);

    // LW 0x10
    drive(2'b00, 32'h10, 32'h0, 32'h0);
    tick(); req_valid = 1'b0;
    check("lw_c1_rd", a_mem_read, 1);
    check("lw_c1_addr", a_mem_address, 32'h10);
    check("lw_c1_flags", {a_mem_write, a_ldw_sdw, a_second_cycle, a_req_ready}, 0);
    tick(); check("lw_c2_resp", a_resp_valid, 0);
    tick(); check("lw_c3_resp", a_resp_valid, 1);
    check("lw_c3_rdata0", a_resp_rdata0, 32'hDEADBEEF);
    check("lw_c3_err", a_resp_err, 0);
    tick(); check("lw_c4_resp", a_resp_valid, 0);
    check("lw_c4_ready", a_req_ready, 1);
    tick(); check("lw_b_c5_resp", b_resp_valid, 1);
    check("lw_b_c5_rdata0", b_resp_rdata0, 32'hDEADBEEF);
    repeat (2) tick();

    // SDW 0x20
    drive(2'b11, 32'h20, 32'h11111111, 32'h22222222);
    tick(); req_valid = 1'b0;
    check("sdw_c1_flags", {a_mem_write, a_mem_read, a_ldw_sdw, a_second_cycle}, 4'b1010);
    check("sdw_c1_addr", a_mem_address, 32'h20);
    check("sdw_c1_data", a_mem_data_out, 32'h11111111);
    tick();
    check("sdw_c2_flags", {a_mem_write, a_mem_read, a_ldw_sdw, a_second_cycle}, 4'b1011);
    check("sdw_c2_addr", a_mem_address, 32'h21);
    check("sdw_c2_data", a_mem_data_out, 32'h22222222);
    tick();
    check("sdw_c3_resp", {a_resp_valid, a_resp_err}, 2'b10);
    check("sdw_c3_idle_bus", {a_mem_write, a_mem_read, a_ldw_sdw, a_second_cycle}, 0);
    check("sdw_c3_addr", a_mem_address, 0);
    check("sdw_c3_rdata_hold", a_resp_rdata0, 32'hDEADBEEF);
    repeat (3) tick();

    // LDW 0x40
    drive(2'b10, 32'h40, 32'h0, 32'h0);
    tick(); req_valid = 1'b0;
    check("ldw_b_c1_flags", {b_mem_read, b_mem_write, b_ldw_sdw, b_second_cycle}, 4'b1010);
    check("ldw_b_c1_addr", b_mem_address, 32'h40);
    tick();
    check("ldw_b_c2_flags", {b_mem_read, b_mem_write, b_ldw_sdw, b_second_cycle}, 4'b1011);
    check("ldw_b_c2_addr", b_mem_address, 32'h41);
    tick(); tick();
    check("ldw_a_c4_resp", a_resp_valid, 1);
    check("ldw_a_c4_rdata", {a_resp_rdata0[15:0], a_resp_rdata1[15:0]}, 32'h000A000B);
    tick(); check("ldw_b_c5_resp", b_resp_valid, 0);
    tick();
    check("ldw_b_c6_resp", {b_resp_valid, b_resp_err}, 2'b10);
    check("ldw_b_c6_rdata0", b_resp_rdata0, 32'hA);
    check("ldw_b_c6_rdata1", b_resp_rdata1, 32'hB);
    tick(); check("ldw_b_c7_resp", b_resp_valid, 0);
    repeat (2) tick();

    // Misaligned LDW 0x41
    snap = a_strobes;
    drive(2'b10, 32'h41, 32'h0, 32'h0);
    tick(); req_valid = 1'b0;
    check("mis_a_c1_resp", {a_resp_valid, a_resp_err}, 2'b11);
    check("mis_b_c1_resp", {b_resp_valid, b_resp_err}, 2'b11);
    check("mis_a_rdata0", a_resp_rdata0, 32'hA);
    check("mis_a_rdata1", a_resp_rdata1, 32'hB);
    tick(); check("mis_a_c2_resp", {a_resp_valid, a_resp_err}, 0);
    repeat (3) tick();
    check("mis_no_strobes", a_strobes - snap, 0);

    // LDW at 0xFFFFFFFE
    drive(2'b10, 32'hFFFFFFFE, 32'h0, 32'h0);
    tick(); req_valid = 1'b0;
    check("wrap_c1_addr", a_mem_address, 32'hFFFFFFFE);
    tick(); check("wrap_c2_addr", a_mem_address, 32'hFFFFFFFF);
    tick(); tick();
    check("wrap_c4_resp", a_resp_valid, 1);
    check("wrap_rdata0", a_resp_rdata0, 32'hA5A5FFFE);
    check("wrap_rdata1", a_resp_rdata1, 32'hA5A5FFFF);
    repeat (4) tick();

    // Reset asserted during ACC2 of an SDW
    snap = a_resps;
    drive(2'b11, 32'h30, 32'h33, 32'h44);
    tick(); req_valid = 1'b0;
    tick();
    check("rstmid_acc2", {a_mem_write, a_second_cycle}, 2'b11);
    #1 reset = 1'b1;
    #1;
    check("rstmid_strobes", {a_mem_read, a_mem_write, a_ldw_sdw, a_second_cycle}, 0);
    check("rstmid_addr", a_mem_address, 0);
    check("rstmid_rdata", a_resp_rdata0 | a_resp_rdata1, 0);
    tick(); reset = 1'b0;
    tick(); check("rstmid_ready", a_req_ready, 1);
    repeat (3) tick();
    check("rstmid_no_resp", a_resps - snap, 0);

    drive(2'b00, 32'h10, 32'h0, 32'h0);
    tick(); req_valid = 1'b0;
    check("post_rst_lw_rd", a_mem_read, 1);
    tick(); tick();
    check("post_rst_lw_resp", a_resp_valid, 1);
    check("post_rst_lw_rdata", a_resp_rdata0, 32'hDEADBEEF);
    repeat (4) tick();

    // Three back-to-back SW with req_valid held high
    snap = accepts;
    drive(2'b01, 32'h50, 32'h100, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) req_wdata0 = 32'h200;
      if (c == 4) req_wdata0 = 32'h300;
      if (c == 7) req_valid = 1'b0;
      check($sformatf("b2b_resp_c%0d", c), a_resp_valid, exp_resp[c]);
      check($sformatf("b2b_wr_c%0d", c), a_mem_write, exp_wr[c]);
      check($sformatf("b2b_data_c%0d", c), a_mem_data_out, exp_wd[c]);
    end
    tick();
    check("b2b_accepts", accepts - snap, 3);
    check("no_overlap", overlaps, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
